pmul_serial_acc: RTL and testbench

- Downstream consumer of the bit-serial coefficient slice stage in the basic polynomial multiplier.
- Each cycle it takes one bit-slice of the K coefficients of operand B (bit t of every b_j, LSB first) and multiplies it against the parallel coefficients of operand A, which are latched at start.
- It shift-accumulates the partial products into the 2K-1 product coefficients c_m = sum over i+j=m of a_i*b_j.
- After N slices it presents the full unsigned, unreduced product polynomial with a one-cycle valid pulse.

---
 rtl/pmul_serial_acc.sv | 110 +++++++++++
 tb/tb_pmul_serial_acc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pmul_serial_acc.sv
// rtl/pmul_serial_acc.sv - bit-serial polynomial multiply shift-accumulator
// Latches operand A on start, then folds one bit-slice of operand B per cycle into 2K-1 coefficient accumulators.
module pmul_serial_acc #(
    parameter int N = 4,
    parameter int K = 4,
    parameter int W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [K*N-1:0]         adata,
    input  logic [K-1:0]           dcoeff,
    output logic [(2*K-1)*W-1:0]   cdata,
    output logic                   busy,
    output logic                   valid
);

    localparam int M  = 2 * K - 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    a_q   [K];
    logic [N-1:0]    a_d   [K];
    logic [W-1:0]    acc_q [M];
    logic [W-1:0]    acc_d [M];
    logic [W-1:0]    pp    [M];

    // Partial product of the current B slice: every a_i whose paired b_j bit is set lands on coefficient i+j.
    always_comb begin
        for (int m = 0; m < M; m++) begin
            pp[m] = '0;
        end
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                if (dcoeff[j]) begin
                    pp[i+j] = pp[i+j] + W'(a_q[i]);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    for (int i = 0; i < K; i++) begin
                        a_d[i] = adata[i*N +: N];
                    end
                    for (int m = 0; m < M; m++) begin
                        acc_d[m] = '0;
                    end
                end
            end
            RUN: begin
                for (int m = 0; m < M; m++) begin
                    acc_d[m] = acc_q[m] + (pp[m] << cnt_q);
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < K; i++) begin
                a_q[i] <= '0;
            end
            for (int m = 0; m < M; m++) begin
                acc_q[m] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
        end
    end

    for (genvar g = 0; g < M; g++) begin : g_cdata
        assign cdata[g*W +: W] = acc_q[g];
    end

    assign busy  = (state_q != IDLE);
    assign valid = (state_q == DONE);

endmodule

// File: tb/tb_pmul_serial_acc.sv
// tb/tb_pmul_serial_acc.sv - randomized self-checking bench for pmul_serial_acc
// Reference product is plain schoolbook multiplication of the coefficient arrays.
module tb_pmul_serial_acc;

    localparam int N = 4;
    localparam int K = 4;
    localparam int W = 10;
    localparam int M = 2 * K - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [K*N-1:0]       adata;
    logic [K-1:0]         dcoeff;
    logic [M*W-1:0]       cdata;
    logic                 busy;
    logic                 valid;

    int vectors     = 0;
    int miscompares = 0;
    int vcount      = 0;
    int vexp        = 0;

    pmul_serial_acc #(.N(N), .K(K), .W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .adata  (adata),
        .dcoeff (dcoeff),
        .cdata  (cdata),
        .busy   (busy),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid === 1'b1) vcount++;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [K*N-1:0] pack_a(input int a[K]);
        logic [K*N-1:0] p;
        p = '0;
        for (int i = 0; i < K; i++) p[i*N +: N] = a[i][N-1:0];
        return p;
    endfunction

    function automatic logic [K-1:0] slice_of(input int b[K], input int t);
        logic [K-1:0] s;
        for (int j = 0; j < K; j++) s[j] = ((b[j] >> t) & 1) != 0;
        return s;
    endfunction

    task automatic check_result(input string tag, input int a[K], input int b[K]);
        int c;
        for (int m = 0; m < M; m++) begin
            c = 0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    if (i + j == m) c += a[i] * b[j];
            check($sformatf("%s c%0d", tag, m), longint'(cdata[m*W +: W]), longint'(c % (1 << W)));
        end
    endtask

    // Caller is #1 after an edge in IDLE. pulse_run: extra start at E2 with junk A;
    // start_done: start raised in the DONE cycle; hold: leave start high afterwards.
    task automatic run_op(input string tag, input int a[K], input int b[K],
                          input bit pulse_run, input bit start_done, input bit hold);
        start  = 1'b1;
        adata  = pack_a(a);
        dcoeff = K'($urandom);
        @(posedge clk); #1;
        start  = 1'b0;
        adata  = K*N'($urandom);
        dcoeff = slice_of(b, 0);
        check({tag, " busy_run"}, longint'(busy), 1);
        check({tag, " valid_run"}, longint'(valid), 0);
        for (int t = 1; t < N; t++) begin
            @(posedge clk); #1;
            dcoeff = slice_of(b, t);
            start  = (pulse_run && t == 1);
            if (valid !== 1'b0) check({tag, " early_valid"}, longint'(valid), 0);
        end
        @(posedge clk); #1;
        start  = start_done || hold;
        dcoeff = K'($urandom);
        check({tag, " valid_done"}, longint'(valid), 1);
        check({tag, " busy_done"}, longint'(busy), 1);
        check_result(tag, a, b);
        vexp++;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        check({tag, " valid_idle"}, longint'(valid), 0);
        check({tag, " busy_idle"}, longint'(busy), 0);
        check_result({tag, " hold"}, a, b);
    endtask

    initial begin
        int a[K];
        int b[K];
        int a2[K];
        int b2[K];
        reset  = 1'b1;
        start  = 1'b0;
        adata  = '0;
        dcoeff = '0;
        #12;
        check("rst cdata", longint'(cdata), 0);
        check("rst busy", longint'(busy), 0);
        check("rst valid", longint'(valid), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dcoeff = K'($urandom);
            @(posedge clk); #1;
            check("idle cdata", longint'(cdata), 0);
            check("idle busy", longint'(busy), 0);
            check("idle valid", longint'(valid), 0);
        end

        a = '{1, 2, 3, 4};
        b = '{5, 6, 7, 8};
        run_op("basic", a, b, 0, 0, 0);

        a = '{15, 15, 15, 15};
        b = '{15, 15, 15, 15};
        run_op("max", a, b, 0, 0, 0);

        a = '{1, 2, 3, 4};
        b = '{5, 6, 7, 8};
        run_op("ignore", a, b, 1, 1, 0);
        check("ignore vcount", longint'(vcount), longint'(vexp));

        // Abort mid-run with an asynchronous reset.
        start = 1'b1;
        adata = K*N'($urandom);
        @(posedge clk); #1;
        start  = 1'b0;
        dcoeff = K'($urandom);
        @(posedge clk); #1;
        dcoeff = K'($urandom);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("abort cdata", longint'(cdata), 0);
        check("abort busy", longint'(busy), 0);
        check("abort valid", longint'(valid), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        a = '{1, 0, 0, 0};
        b = '{0, 0, 0, 9};
        run_op("post_rst", a, b, 0, 0, 0);
        check("abort vcount", longint'(vcount), longint'(vexp));

        // Back-to-back with start held high; second op must not see first result.
        a  = '{15, 15, 15, 15};
        b  = '{15, 15, 15, 15};
        a2 = '{3, 0, 1, 2};
        b2 = '{1, 4, 0, 2};
        run_op("b2b_1", a, b, 0, 0, 1);
        run_op("b2b_2", a2, b2, 0, 0, 0);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < K; i++) begin
                a[i] = int'($urandom_range(0, (1 << N) - 1));
                b[i] = int'($urandom_range(0, (1 << N) - 1));
            end
            run_op($sformatf("rnd%0d", r), a, b, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("total vcount", longint'(vcount), longint'(vexp));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
